// File: rtl/apb_spi_arbiter.sv
// Round-robin arbiter that serialises single read/write transfers from NREQ
// requesters onto one APB master port, with a bounded PREADY wait.
module apb_spi_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*WIDTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [WIDTH-1:0]      PADDR,
    output logic [WIDTH-1:0]      PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [WIDTH-1:0]      PRDATA
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pwrite;
    logic [WIDTH-1:0]   r_paddr;
    logic [WIDTH-1:0]   r_pwdata;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rsp_timeout;

    logic               w_any;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_done;
    logic               w_tout;
    logic [NREQ-1:0]    w_req_ready;

    // Rotating priority search: walk offsets from the highest down so the
    // requester closest to r_ptr is the last (winning) assignment.
    always_comb begin
        int v_idx;
        v_idx  = 0;
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_gidx = IDX_W'(v_idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign w_req_ready[gi] = (r_state == S_IDLE) && w_any && !reset &&
                                     (w_gidx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_tout       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_done       = 1'b1;
                    w_tout       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_pwrite <= req_write[w_gidx];
                        r_paddr  <= req_addr[w_gidx*WIDTH +: WIDTH];
                        r_pwdata <= req_wdata[w_gidx*WIDTH +: WIDTH];
                        r_gnt    <= w_gidx;
                        r_ptr    <= (w_gidx == IDX_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
                    end
                end
                S_SETUP: begin
                    r_cnt <= '0;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid   <= NREQ'(1) << r_gnt;
                        r_rsp_rdata   <= (w_tout || r_pwrite) ? '0 : PRDATA;
                        r_rsp_err     <= w_tout | PSLVERR;
                        r_rsp_timeout <= w_tout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != S_IDLE);
    assign PSEL        = (r_state != S_IDLE);
    assign PENABLE     = (r_state == S_ACCESS);
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// Directed bench for apb_spi_arbiter: a per-cycle vector table for basic
// transfers plus hand sequences for round robin, timeout and reset.
module tb_apb_spi_arbiter;

    logic        PCLK = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  PRDATA;

    int checks = 0;
    int failures = 0;

    apb_spi_arbiter #(.WIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rw;
        logic       prdy;
        logic       pslv;
        logic [7:0] prdata;
        logic [3:0] e_rdy;
        logic       e_psel;
        logic       e_pen;
        logic [7:0] e_paddr;
        logic [7:0] e_pwdata;
        logic       e_pwr;
        logic [3:0] e_rspv;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_to;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // Read from requester 2 with PREADY low; when last_ready is set, PREADY
    // rises on the 16th ACCESS cycle and the transfer completes normally.
    task automatic run_timeout(input logic last_ready);
        int n;
        bit ended;
        n = 0;
        ended = 0;
        @(negedge PCLK);
        req_valid = 4'b0100; req_write = 4'b0000; PREADY = 0; PRDATA = 8'hFF;
        #1 chk("to_accept", 32'(req_ready), 32'h4);
        @(negedge PCLK);
        req_valid = 4'b0000;
        #1 chk("to_setup", 32'({PSEL, PENABLE}), 32'h2);
        for (int guard = 0; guard < 40 && !ended; guard++) begin
            @(negedge PCLK);
            PREADY = (last_ready && n == 15);
            #1;
            if (PSEL && PENABLE) n++;
            else ended = 1;
        end
        PREADY = 0;
        chk("to_access_cycles", 32'(n), 16);
        chk("to_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("to_rsp_err", 32'(rsp_err), last_ready ? 0 : 1);
        chk("to_rsp_timeout", 32'(rsp_timeout), last_ready ? 0 : 1);
        chk("to_rsp_rdata", 32'(rsp_rdata), last_ready ? 32'hFF : 0);
        $display("tb: timeout-path read req2 last_ready=%0d access_cycles=%0d err=%0d to=%0d",
                 last_ready, n, rsp_err, rsp_timeout);
    endtask

    initial begin
        // requester i: addr/wdata slices
        req_addr  = {8'h40, 8'h30, 8'h12, 8'h20};
        req_wdata = {8'hD4, 8'hC3, 8'hA5, 8'hB1};
        req_valid = 0; req_write = 0; PREADY = 0; PSLVERR = 0; PRDATA = 0;
        reset = 1;

        //            rv      rw      rdy pslv prd    e_rdy  ps pe paddr  pwdata pwr rspv    rdata  err to
        vecs[0]  = '{4'b0010, 4'b0010, 1, 0, 8'h00, 4'b0010, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 0, 0};
        vecs[1]  = '{4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 1, 0, 8'h12, 8'hA5, 1, 4'b0000, 8'h00, 0, 0};
        vecs[2]  = '{4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 1, 1, 8'h12, 8'hA5, 1, 4'b0000, 8'h00, 0, 0};
        vecs[3]  = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 0, 4'b0010, 8'h00, 0, 0};
        vecs[4]  = '{4'b1000, 4'b0000, 0, 0, 8'h00, 4'b1000, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 0, 0};
        vecs[5]  = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 1, 0, 8'h40, 8'hD4, 0, 4'b0000, 8'h00, 0, 0};
        vecs[6]  = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 1, 1, 8'h40, 8'hD4, 0, 4'b0000, 8'h00, 0, 0};
        vecs[7]  = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 1, 1, 8'h40, 8'hD4, 0, 4'b0000, 8'h00, 0, 0};
        vecs[8]  = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 1, 1, 8'h40, 8'hD4, 0, 4'b0000, 8'h00, 0, 0};
        vecs[9]  = '{4'b0000, 4'b0000, 1, 0, 8'h3C, 4'b0000, 1, 1, 8'h40, 8'hD4, 0, 4'b0000, 8'h00, 0, 0};
        vecs[10] = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 0, 4'b1000, 8'h3C, 0, 0};
        vecs[11] = '{4'b0001, 4'b0001, 0, 0, 8'h00, 4'b0001, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h3C, 0, 0};
        vecs[12] = '{4'b0000, 4'b0000, 1, 1, 8'h00, 4'b0000, 1, 0, 8'h20, 8'hB1, 1, 4'b0000, 8'h3C, 0, 0};
        vecs[13] = '{4'b0000, 4'b0000, 1, 1, 8'h00, 4'b0000, 1, 1, 8'h20, 8'hB1, 1, 4'b0000, 8'h3C, 0, 0};
        vecs[14] = '{4'b0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 0, 4'b0001, 8'h00, 1, 0};

        repeat (3) @(negedge PCLK);
        #1 check_reset_outputs();
        @(negedge PCLK);
        reset = 0;

        // write req1, read req3 with 3 wait states, write req0 with PSLVERR
        for (int i = 0; i < 15; i++) begin
            @(negedge PCLK);
            req_valid = vecs[i].rv; req_write = vecs[i].rw;
            PREADY = vecs[i].prdy; PSLVERR = vecs[i].pslv; PRDATA = vecs[i].prdata;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_psel", i), 32'(PSEL), 32'(vecs[i].e_psel));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_psel));
            chk($sformatf("v%0d_penable", i), 32'(PENABLE), 32'(vecs[i].e_pen));
            if (vecs[i].e_psel) begin
                chk($sformatf("v%0d_paddr", i), 32'(PADDR), 32'(vecs[i].e_paddr));
                chk($sformatf("v%0d_pwdata", i), 32'(PWDATA), 32'(vecs[i].e_pwdata));
                chk($sformatf("v%0d_pwrite", i), 32'(PWRITE), 32'(vecs[i].e_pwr));
            end
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rspv));
            chk($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_rsp_timeout", i), 32'(rsp_timeout), 32'(vecs[i].e_to));
            if (rsp_valid != 0)
                $display("tb: rsp valid=%b rdata=0x%02h err=%0d to=%0d", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end

        // Round robin: all four requesters pending from reset, reads
        @(negedge PCLK);
        reset = 1; req_valid = 4'b1111; req_write = 4'b0000;
        PREADY = 1; PSLVERR = 0; PRDATA = 8'h77;
        repeat (2) @(negedge PCLK);
        reset = 0;
        for (int t = 0; t < 16; t++) begin
            logic [3:0] e_rdy;
            logic [3:0] e_rspv;
            if (t > 0) @(negedge PCLK);
            if (t == 15) req_valid = 4'b0000;
            #1;
            e_rdy  = (t % 3 == 0 && t < 15) ? 4'(1 << ((t / 3) % 4)) : 4'b0000;
            e_rspv = (t % 3 == 0 && t > 0) ? 4'(1 << ((t / 3 - 1) % 4)) : 4'b0000;
            chk($sformatf("rr%0d_req_ready", t), 32'(req_ready), 32'(e_rdy));
            chk($sformatf("rr%0d_rsp_valid", t), 32'(rsp_valid), 32'(e_rspv));
            if (e_rspv != 0) begin
                chk($sformatf("rr%0d_rsp_rdata", t), 32'(rsp_rdata), 32'h77);
                $display("tb: rr rsp valid=%b rdata=0x%02h", rsp_valid, rsp_rdata);
            end
        end
        PREADY = 0;

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Reset during ACCESS wait states
        @(negedge PCLK);
        req_valid = 4'b0010; req_write = 4'b0000; PREADY = 0;
        #1 chk("rm_accept", 32'(req_ready), 32'h2);
        @(negedge PCLK);
        req_valid = 4'b0000;
        repeat (3) @(negedge PCLK);
        #1 chk("rm_in_access", 32'({PSEL, PENABLE}), 32'h3);
        reset = 1;
        @(negedge PCLK);
        #1 chk("rm_psel_penable", 32'({PSEL, PENABLE}), 32'h0);
        reset = 0; PREADY = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            #1 chk($sformatf("rm_no_rsp%0d", i), 32'(rsp_valid), 32'h0);
        end
        PREADY = 0;
        @(negedge PCLK);
        req_valid = 4'b1010;
        #1 chk("rm_ptr_zero_grant", 32'(req_ready), 32'h2);
        $display("tb: reset-mid-access then grant req_ready=%b", req_ready);
        @(negedge PCLK);
        req_valid = 4'b0000;
        repeat (3) @(negedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
